// File: rtl/writeback_regfile.sv
// Writeback stage of the RV32I pipeline: selects the result, writes the 32x32
// register file, serves two decode read ports and keeps the cycle/instret counters.
module writeback_regfile #(
    parameter bit BYPASS_EN = 1'b1,
    parameter int COUNTER_W = 64
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_in_regWrite,
    input  logic [2:0]           wb_in_memtoReg,
    input  logic [31:0]          wb_in_aluOut,
    input  logic [31:0]          wb_in_dataMemOut,
    input  logic [31:0]          wb_in_immediate,
    input  logic [31:0]          wb_in_imm_plus_pc_or_rs1,
    input  logic [31:0]          wb_in_pc_plus_four,
    input  logic [4:0]           wb_in_rd,
    input  logic [31:0]          wb_in_instr,
    input  logic [4:0]           rs1_addr,
    input  logic [4:0]           rs2_addr,
    output logic [31:0]          rs1_data,
    output logic [31:0]          rs2_data,
    output logic [4:0]           wb_out_rd_to_execute,
    output logic                 wb_out_regWrite_to_execute,
    output logic [31:0]          wb_out_result_to_execute,
    output logic [COUNTER_W-1:0] cycle_count,
    output logic [COUNTER_W-1:0] instret_count
);

    logic [31:0]             result;
    logic                    sel_valid;
    logic                    we;
    logic                    bubble;
    logic [31:1][31:0]       regs_q, regs_d;
    logic [31:0][31:0]       rf_view;
    logic [COUNTER_W-1:0]    cycle_q, cycle_d;
    logic [COUNTER_W-1:0]    instret_q, instret_d;

    always_comb begin
        result    = 32'h0;
        sel_valid = 1'b1;
        case (wb_in_memtoReg)
            3'b000:  result = wb_in_aluOut;
            3'b001:  result = wb_in_dataMemOut;
            3'b010:  result = wb_in_immediate;
            3'b011:  result = wb_in_imm_plus_pc_or_rs1;
            3'b100:  result = wb_in_pc_plus_four;
            default: sel_valid = 1'b0;
        endcase
    end

    assign we = wb_in_regWrite && (wb_in_rd != 5'd0) && sel_valid;

    assign wb_out_rd_to_execute       = wb_in_rd;
    assign wb_out_regWrite_to_execute = we;
    assign wb_out_result_to_execute   = result;

    // x0 is a hardwired zero slot so the read ports can index uniformly.
    assign rf_view = {regs_q, 32'h0};

    always_comb begin
        rs1_data = 32'h0;
        if (rs1_addr != 5'd0) begin
            if (BYPASS_EN && we && (wb_in_rd == rs1_addr))
                rs1_data = result;
            else
                rs1_data = rf_view[rs1_addr];
        end
    end

    always_comb begin
        rs2_data = 32'h0;
        if (rs2_addr != 5'd0) begin
            if (BYPASS_EN && we && (wb_in_rd == rs2_addr))
                rs2_data = result;
            else
                rs2_data = rf_view[rs2_addr];
        end
    end

    always_comb begin
        regs_d = regs_q;
        for (int i = 1; i < 32; i++) begin
            if (we && (wb_in_rd == 5'(i)))
                regs_d[i] = result;
        end
    end

    // Stores and branches retire too, so retirement ignores the write enable.
    assign bubble    = (wb_in_instr == 32'h0000_0000) || (wb_in_instr == 32'h0000_0013);
    assign cycle_d   = cycle_q + COUNTER_W'(1);
    assign instret_d = bubble ? instret_q : instret_q + COUNTER_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q    <= '0;
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            regs_q    <= regs_d;
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_count   = cycle_q;
    assign instret_count = instret_q;

endmodule

// File: doc/writeback_regfile.md
# writeback_regfile

Final (WB) stage of the five-stage RV32I pipeline, fed directly by the MEM/WB register outputs of the memory stage. It selects the architectural result with `memtoReg` and writes it into the 32×32 integer register file. It also serves the decode stage's two read ports, with same-cycle write-through bypass, and provides the WB-level forwarding view to execute. It maintains the cycle and retired-instruction counters.

## Interface
Parameters:
- BYPASS_EN, 1, 1 = read ports return the value being written this cycle; 0 = read ports return stored contents only.
- COUNTER_W, 64, width of `cycle_count` and `instret_count`.

Ports:
- clk  in  1  pipeline clock; all state updates on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- wb_in_regWrite  in  1  register-write enable from MEM/WB.
- wb_in_memtoReg  in  3  result select from MEM/WB.
- wb_in_aluOut  in  32  ALU result.
- wb_in_dataMemOut  in  32  load data, already sized/extended by dmem.
- wb_in_immediate  in  32  U-immediate (LUI).
- wb_in_imm_plus_pc_or_rs1  in  32  AUIPC result.
- wb_in_pc_plus_four  in  32  link value (JAL/JALR).
- wb_in_rd  in  5  destination register.
- wb_in_instr  in  32  instruction word; used only for retire counting.
- rs1_addr, rs2_addr  in  5 each  decode-stage read addresses.
- rs1_data, rs2_data  out  32 each  read data.
- wb_out_rd_to_execute  out  5  equals wb_in_rd.
- wb_out_regWrite_to_execute  out  1  effective write enable (see Operation).
- wb_out_result_to_execute  out  32  selected result, for forwarding.
- cycle_count  out  COUNTER_W  cycles since reset release.
- instret_count  out  COUNTER_W  retired non-bubble instructions.

## Operation
- Result mux on `wb_in_memtoReg`:
  - 000 → aluOut
  - 001 → dataMemOut
  - 010 → immediate
  - 011 → imm_plus_pc_or_rs1
  - 100 → pc_plus_four
  - 101–111 → result 32'h0 and write suppressed.
- Effective write `we = wb_in_regWrite && wb_in_rd != 0 && memtoReg <= 3'b100`. `wb_out_regWrite_to_execute = we`.
- Register file: x1–x31 are flops. x0 is not stored and always reads 0. Writes to x0 are dropped.
- Read ports are combinational. Address 0 → 0. Otherwise, if BYPASS_EN and `we` and `rd == rsX_addr`, return the current result; else return the stored value. Both ports bypass independently, including when rs1 == rs2 == rd.
- Bubble = `wb_in_instr` equal to 32'h0000_0000 or 32'h0000_0013 (canonical NOP).
- instret_count increments once per cycle when the instruction is not a bubble. This holds regardless of `we`, so stores and branches count.
- cycle_count increments every cycle while rst_n is high.
- Both counters wrap modulo 2^COUNTER_W with no saturation.

## Timing
- Reset (asynchronous assert, synchronous release at the next edge): all 31 registers = 0, cycle_count = 0, instret_count = 0. Combinational outputs follow their inputs; rs*_data reads 0 during reset unless bypassed.
- Reset asserted mid-operation clears all state immediately, without waiting for a clock edge. A write presented in the same cycle is lost.
- Write latency: result is stored at the rising edge ending the WB cycle. Without bypass it is visible on the read ports in the next cycle; with bypass it is visible in the same cycle.
- Forwarding outputs are purely combinational from the `wb_in_*` inputs, with zero latency.
- First rising edge after rst_n deasserts: cycle_count 0→1.
- No handshake or stall. The block accepts a new WB input every cycle.

## Test plan
- Reset then ALU write:
  - Stimulus: assert rst_n=0; release; present regWrite=1, memtoReg=000, rd=5, aluOut=32'hDEAD_BEEF; set rs1_addr=5 with BYPASS_EN=1.
  - Required: rs1_data = DEADBEEF in the same cycle. After the edge, with regWrite=0, rs1_data still = DEADBEEF.
- Mux coverage:
  - Stimulus: write rd=1..5 with memtoReg 000..100, each input set to a distinct value (e.g. 32'h1111_1111 × n).
  - Required: each register reads back its selected source.
  - Stimulus: memtoReg=111, rd=6.
  - Required: x6 stays 0 and wb_out_regWrite_to_execute = 0.
- x0 protection:
  - Stimulus: regWrite=1, rd=0, aluOut=32'hFFFF_FFFF; read rs1_addr=rs2_addr=0.
  - Required: both read ports = 0 and wb_out_regWrite_to_execute = 0.
- Bypass off/on:
  - Stimulus: BYPASS_EN=0, x7 holds 32'h0000_0001, write x7 ← 32'h0000_0002 while reading x7.
  - Required: reads 1 in the write cycle, 2 in the next cycle.
  - Required with BYPASS_EN=1: reads 2 in the write cycle.
- Counters:
  - Stimulus: after reset, 10 cycles with instr alternating 32'h0000_0013 and 32'h0050_0293.
  - Required: cycle_count = 10, instret_count = 5.
  - Stimulus: COUNTER_W=4, 17 non-bubble cycles.
  - Required: both counters = 1.
- Async reset mid-run:
  - Stimulus: populate x1–x31; drop rst_n between clock edges.
  - Required: all reads return 0 and both counters = 0 before the next edge.
